// File: rtl/dotp_pkg.sv
// Shared types and constants for the dot-product sequencer.
// FSM states, flush length and accumulator width helper.
package dotp_pkg;

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_FLUSH = 2'd1,
        S_OUT   = 2'd2
    } state_t;

    localparam int FLUSH_LEN = 2;

    function automatic int acc_width(input int nb_data, input int n_words);
        return 2 * nb_data + $clog2(n_words);
    endfunction

endpackage

// File: rtl/dotp_mac_stage.sv
// Multiply-accumulate datapath: even-word latch, product register
// and accumulator, each cleared together on frame end or abort.
module dotp_mac_stage #(
    parameter int NB_DATA = 8,
    parameter int ACC_W   = 21
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               i_clear,
    input  logic               i_latch,
    input  logic               i_mul,
    input  logic [NB_DATA-1:0] i_data,
    output logic [ACC_W-1:0]   o_acc
);

    localparam int PW = 2 * NB_DATA;

    logic [NB_DATA-1:0] r_a;
    logic [PW-1:0]      r_prod;
    logic               r_prod_vld;
    logic [ACC_W-1:0]   r_acc;

    logic [PW-1:0]      w_a_ext;
    logic [PW-1:0]      w_d_ext;
    logic [PW-1:0]      w_prod;
    logic [ACC_W-1:0]   w_prod_ext;

    // Low PW bits of a product of sign-extended operands equal the signed product
    assign w_a_ext    = {{NB_DATA{r_a[NB_DATA-1]}}, r_a};
    assign w_d_ext    = {{NB_DATA{i_data[NB_DATA-1]}}, i_data};
    assign w_prod     = w_a_ext * w_d_ext;
    assign w_prod_ext = {{(ACC_W-PW){r_prod[PW-1]}}, r_prod};
    assign o_acc      = r_acc;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_a        <= '0;
            r_prod     <= '0;
            r_prod_vld <= 1'b0;
            r_acc      <= '0;
        end else if (i_clear) begin
            r_a        <= '0;
            r_prod     <= '0;
            r_prod_vld <= 1'b0;
            r_acc      <= '0;
        end else begin
            if (i_latch)
                r_a <= i_data;
            if (i_mul)
                r_prod <= w_prod;
            r_prod_vld <= i_mul;
            if (r_prod_vld)
                r_acc <= r_acc + w_prod_ext;
        end
    end

endmodule

// File: rtl/dot_product_sequencer.sv
// Frame sequencer: accepts N_WORDS signed words, emits the sum of
// pairwise products through a valid/ready result handshake.
module dot_product_sequencer
    import dotp_pkg::*;
#(
    parameter  int N_WORDS = 32,
    parameter  int NB_DATA = 8,
    localparam int ACC_W   = acc_width(NB_DATA, N_WORDS)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               i_valid,
    input  logic [NB_DATA-1:0] i_data,
    output logic               o_ready,
    input  logic               i_abort,
    output logic               o_valid,
    output logic [ACC_W-1:0]   o_data,
    input  logic               i_ready,
    output logic               o_busy
);

    localparam int         CNT_W      = $clog2(N_WORDS);
    localparam logic [1:0] FLUSH_LAST = 2'(FLUSH_LEN - 1);

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [1:0]         r_flush;
    logic               r_valid;
    logic [ACC_W-1:0]   r_data;
    logic [ACC_W-1:0]   w_acc;
    logic               w_accept;
    logic               w_last;
    logic               w_ohs;
    logic               w_clear;
    logic               w_to_out;

    assign o_ready  = (r_state == S_LOAD);
    assign w_accept = i_valid & o_ready & ~i_abort;
    assign w_last   = (r_cnt == CNT_W'(N_WORDS - 1));
    assign w_ohs    = (r_state == S_OUT) & r_valid & i_ready;
    assign w_clear  = i_abort | w_ohs;
    assign w_to_out = (r_state == S_FLUSH) && (w_next == S_OUT);
    assign o_valid  = r_valid;
    assign o_data   = r_data;
    assign o_busy   = (r_cnt != '0) | (r_state != S_LOAD);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_LOAD:  if (w_accept && w_last) w_next = S_FLUSH;
            S_FLUSH: if (r_flush == FLUSH_LAST) w_next = S_OUT;
            S_OUT:   if (w_ohs) w_next = S_LOAD;
            default: w_next = S_LOAD;
        endcase
        // Abort wins over every transition, including the output handshake
        if (i_abort)
            w_next = S_LOAD;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_LOAD;
            r_cnt   <= '0;
            r_flush <= '0;
            r_valid <= 1'b0;
            r_data  <= '0;
        end else begin
            r_state <= w_next;
            if (w_clear)
                r_cnt <= '0;
            else if (w_accept)
                r_cnt <= r_cnt + 1'b1;
            if (r_state == S_FLUSH && w_next == S_FLUSH)
                r_flush <= r_flush + 1'b1;
            else
                r_flush <= '0;
            if (i_abort) begin
                r_valid <= 1'b0;
            end else if (w_to_out) begin
                r_valid <= 1'b1;
                r_data  <= w_acc;
            end else if (w_ohs) begin
                r_valid <= 1'b0;
            end
        end
    end

    dotp_mac_stage #(
        .NB_DATA (NB_DATA),
        .ACC_W   (ACC_W)
    ) u_mac (
        .clock   (clock),
        .reset   (reset),
        .i_clear (w_clear),
        .i_latch (w_accept & ~r_cnt[0]),
        .i_mul   (w_accept & r_cnt[0]),
        .i_data  (i_data),
        .o_acc   (w_acc)
    );

endmodule

// File: tb/tb_dot_product_sequencer.sv
// Self-checking bench for dot_product_sequencer: frame-level model
// compared every cycle, plus literal expectations per scenario.
module tb_dot_product_sequencer;

    localparam int N  = 32;
    localparam int NB = 8;
    localparam int AW = 2 * NB + $clog2(N);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_valid = 1'b0;
    logic [NB-1:0] i_data = '0;
    logic          i_abort = 1'b0;
    logic          i_ready = 1'b1;
    logic          o_ready;
    logic          o_valid;
    logic [AW-1:0] o_data;
    logic          o_busy;

    int checks = 0;
    int errors = 0;

    dot_product_sequencer #(
        .N_WORDS (N),
        .NB_DATA (NB)
    ) dut (
        .clock   (clk),
        .reset   (rst),
        .i_valid (i_valid),
        .i_data  (i_data),
        .o_ready (o_ready),
        .i_abort (i_abort),
        .o_valid (o_valid),
        .o_data  (o_data),
        .i_ready (i_ready),
        .o_busy  (o_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: collect accepted words, compute the sum of pair
    // products once the frame is full, publish it two edges later.
    int m_q[$];
    int m_phase = 0;
    int m_wait  = 0;
    int m_res   = 0;
    int m_data  = 0;
    bit m_valid = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_q.delete();
            m_phase = 0;
            m_valid = 1'b0;
            m_data  = 0;
        end else if (i_abort) begin
            m_q.delete();
            m_phase = 0;
            m_valid = 1'b0;
        end else begin
            case (m_phase)
                0: if (i_valid) begin
                    m_q.push_back(int'($signed(i_data)));
                    if (m_q.size() == N) begin
                        m_res = 0;
                        for (int k = 0; k < N; k += 2)
                            m_res += m_q[k] * m_q[k+1];
                        m_q.delete();
                        m_phase = 1;
                        m_wait  = 2;
                    end
                end
                1: begin
                    m_wait--;
                    if (m_wait == 0) begin
                        m_phase = 2;
                        m_valid = 1'b1;
                        m_data  = m_res;
                    end
                end
                default: if (i_ready) begin
                    m_phase = 0;
                    m_valid = 1'b0;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            check("rst_valid", int'(o_valid), 0);
            check("rst_data", int'($signed(o_data)), 0);
            check("rst_busy", int'(o_busy), 0);
        end else begin
            check("cyc_valid", int'(o_valid), int'(m_valid));
            check("cyc_data", int'($signed(o_data)), m_data);
            check("cyc_ready", int'(o_ready), int'(m_phase == 0));
            check("cyc_busy", int'(o_busy), int'(m_phase != 0 || m_q.size() != 0));
        end
    end

    function automatic logic [NB-1:0] word_of(input int kind, input int i);
        logic [NB-1:0] w;
        case (kind)
            0:       w = 8'd1;
            1:       w = (i % 2 == 1) ? 8'd3 : 8'd2;
            2:       w = 8'h80;
            default: w = (i % 2 == 1) ? 8'h7F : 8'h80;
        endcase
        return w;
    endfunction

    task automatic send(input logic [NB-1:0] w, input int gap);
        int guard;
        repeat (gap) begin
            i_valid = 1'b0;
            @(posedge clk);
            #1;
        end
        i_valid = 1'b1;
        i_data  = w;
        guard   = 0;
        while (!o_ready && guard < 100) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (guard >= 100)
            check("ready_timeout", 0, 1);
        @(posedge clk);
        #1;
        i_valid = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!o_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic frame(input int kind, input int exp, input int gapmax);
        int n;
        for (int i = 0; i < N; i++)
            send(word_of(kind, i), gapmax > 0 ? int'($urandom_range(0, gapmax)) : 0);
        wait_valid(n);
        check("latency", n, 2);
        check("result", int'($signed(o_data)), exp);
        if (i_ready) begin
            @(posedge clk);
            #1;
            check("valid_one_cycle", int'(o_valid), 0);
            check("ready_after_hs", int'(o_ready), 1);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int n;
        int held;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("init_ready", int'(o_ready), 1);
        check("init_valid", int'(o_valid), 0);
        check("init_data", int'($signed(o_data)), 0);
        check("init_busy", int'(o_busy), 0);
        @(posedge clk);
        #1;

        frame(0, 16, 0);
        frame(1, 96, 2);
        frame(2, 262144, 0);
        frame(3, -260096, 0);

        // Result held under back-pressure; offered words must be ignored
        i_ready = 1'b0;
        frame(0, 16, 0);
        held = int'($signed(o_data));
        repeat (10) begin
            i_valid = 1'b1;
            i_data  = 8'd5;
            @(posedge clk);
            #1;
            check("hold_valid", int'(o_valid), 1);
            check("hold_data", int'($signed(o_data)), held);
            check("hold_ready", int'(o_ready), 0);
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        @(posedge clk);
        #1;
        check("hold_release", int'(o_valid), 0);
        check("retain_data", int'($signed(o_data)), 16);
        frame(1, 96, 1);

        // Abort after word 17, with a word presented alongside the abort
        for (int i = 0; i < 18; i++)
            send(8'd1, 0);
        i_abort = 1'b1;
        i_valid = 1'b1;
        i_data  = 8'd1;
        @(posedge clk);
        #1;
        i_abort = 1'b0;
        i_valid = 1'b0;
        check("abort_busy", int'(o_busy), 0);
        check("abort_keep", int'($signed(o_data)), 96);
        frame(0, 16, 0);

        // Abort coinciding with the output handshake
        for (int i = 0; i < N; i++)
            send(word_of(3, i), 0);
        wait_valid(n);
        check("abhs_latency", n, 2);
        i_abort = 1'b1;
        @(posedge clk);
        #1;
        i_abort = 1'b0;
        check("abhs_valid", int'(o_valid), 0);
        check("abhs_keep", int'($signed(o_data)), -260096);
        check("abhs_ready", int'(o_ready), 1);

        // Reset mid-frame after word 9
        for (int i = 0; i < 10; i++)
            send(8'd1, 0);
        rst = 1'b1;
        #1;
        check("mrst_valid", int'(o_valid), 0);
        check("mrst_data", int'($signed(o_data)), 0);
        check("mrst_busy", int'(o_busy), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        frame(0, 16, 0);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
